// File: rtl/ysyx_22040632_mul_iter_if.sv
// rtl/ysyx_22040632_mul_iter_if.sv - operand/result handshake bundle for the iterative multiplier
interface ysyx_22040632_mul_iter_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] multiplier;
    logic [XLEN-1:0] multiplicand;
    logic [1:0]      mul_signed;
    logic            mulw;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_lo;
    logic [XLEN-1:0] result_hi;

    modport master (
        output in_valid, multiplier, multiplicand, mul_signed, mulw, out_ready,
        input  in_ready, out_valid, result_lo, result_hi
    );

    modport slave (
        input  in_valid, multiplier, multiplicand, mul_signed, mulw, out_ready,
        output in_ready, out_valid, result_lo, result_hi
    );
endinterface

// File: rtl/ysyx_22040632_mul_iter.sv
// rtl/ysyx_22040632_mul_iter.sv - iterative radix-4 Booth multiplier, optional MUL_EARLY_OUT_EN zero shortcut
module ysyx_22040632_mul_iter #(
    parameter int XLEN         = 64,
    parameter int PP_PER_CYCLE = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    ysyx_22040632_mul_iter_if.slave bus
);
    localparam int EW      = XLEN + 2;
    localparam int MW      = EW + 1;
    localparam int IW      = 2 * XLEN + 4;
    localparam int ND      = EW / 2;
    localparam int ND_W    = (XLEN / 2 + 2) / 2;
    localparam int ITERS   = (ND + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int ITERS_W = (ND_W + PP_PER_CYCLE - 1) / PP_PER_CYCLE;
    localparam int CW      = $clog2(ITERS + 1);
    localparam logic [CW-1:0] LAST   = CW'(ITERS - 1);
    localparam logic [CW-1:0] LAST_W = CW'(ITERS_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   counter;
    logic            is_w_q;
    // Multiplier with the Booth guard bit at [0]; shifted right 2*P bits per cycle.
    logic [MW-1:0]   mplr_q;
    // Multiplicand, its bitwise inverse and the one-hot weight of digit 0 of the
    // current cycle, all shifted left 2*P bits per cycle. Keeping the inverse
    // separately leaves zeros below the digit weight so the +1 of a negated
    // digit lands in its own 2-bit slot and can be merged as a plain bit.
    logic [IW-1:0]   mcand_q;
    logic [IW-1:0]   ncand_q;
    logic [IW-1:0]   pos_q;
    logic [IW-1:0]   sum_q;
    logic [IW-1:0]   carry_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_lo_q;
    logic [XLEN-1:0] result_hi_q;

    logic            sgn_mplr;
    logic            sgn_mcand;
    logic [EW-1:0]   ext_mplr;
    logic [EW-1:0]   ext_mcand;
    logic [IW-1:0]   wide_mcand;

    logic [IW-1:0]   csa_s;
    logic [IW-1:0]   csa_c;
    logic [IW-1:0]   corr;
    logic [IW-1:0]   pp;
    logic [IW-1:0]   t_s;
    logic [2:0]      trip;
    logic            pos1;
    logic            pos2;
    logic            neg1;
    logic            neg2;
    int              nd_lim;
    logic [2*XLEN-1:0] prod;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result_lo = result_lo_q;
    assign bus.result_hi = result_hi_q;

    // Extend both operands to XLEN+2 bits (word ops extend bit 31 first).
    always_comb begin
        sgn_mplr  = bus.mul_signed[0] & (bus.mulw ? bus.multiplier[31]   : bus.multiplier[XLEN-1]);
        sgn_mcand = bus.mul_signed[1] & (bus.mulw ? bus.multiplicand[31] : bus.multiplicand[XLEN-1]);
        if (bus.mulw) begin
            ext_mplr  = {{(EW-32){sgn_mplr}},  bus.multiplier[31:0]};
            ext_mcand = {{(EW-32){sgn_mcand}}, bus.multiplicand[31:0]};
        end else begin
            ext_mplr  = {{2{sgn_mplr}},  bus.multiplier};
            ext_mcand = {{2{sgn_mcand}}, bus.multiplicand};
        end
        wide_mcand = {{(IW-EW){ext_mcand[EW-1]}}, ext_mcand};
    end

    // Booth-decode this cycle's digits and compress them into the sum/carry pair.
    always_comb begin
        csa_s  = sum_q;
        csa_c  = carry_q;
        corr   = '0;
        pp     = '0;
        t_s    = '0;
        trip   = '0;
        pos1   = 1'b0;
        pos2   = 1'b0;
        neg1   = 1'b0;
        neg2   = 1'b0;
        nd_lim = is_w_q ? ND_W : ND;
        for (int k = 0; k < PP_PER_CYCLE; k++) begin
            trip = mplr_q[2*k +: 3];
            pos1 = 1'b0;
            pos2 = 1'b0;
            neg1 = 1'b0;
            neg2 = 1'b0;
            if ((int'(counter) * PP_PER_CYCLE + k) < nd_lim) begin
                case (trip)
                    3'b001, 3'b010: pos1 = 1'b1;
                    3'b011:         pos2 = 1'b1;
                    3'b100:         neg2 = 1'b1;
                    3'b101, 3'b110: neg1 = 1'b1;
                    default:        ;
                endcase
            end
            pp = '0;
            if (pos1) pp = mcand_q << (2*k);
            if (pos2) pp = mcand_q << (2*k + 1);
            if (neg1) pp = ncand_q << (2*k);
            if (neg2) pp = ncand_q << (2*k + 1);
            // -x = ~x + 1 and -2x = (~x << 1) + 2, each at the digit weight.
            if (neg1) corr = corr | (pos_q << (2*k));
            if (neg2) corr = corr | (pos_q << (2*k + 1));
            t_s   = csa_s ^ csa_c ^ pp;
            csa_c = ((csa_s & csa_c) | (csa_s & pp) | (csa_c & pp)) << 1;
            csa_s = t_s;
        end
        t_s   = csa_s ^ csa_c ^ corr;
        csa_c = ((csa_s & csa_c) | (csa_s & corr) | (csa_c & corr)) << 1;
        csa_s = t_s;
    end

    // Carry-propagate of the last compression step; only the low 2*XLEN bits matter.
    always_comb begin
        prod = csa_s[2*XLEN-1:0] + csa_c[2*XLEN-1:0];
    end

    // Control FSM, operand/accumulator registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            counter     <= '0;
            is_w_q      <= 1'b0;
            mplr_q      <= '0;
            mcand_q     <= '0;
            ncand_q     <= '0;
            pos_q       <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_lo_q <= '0;
            result_hi_q <= '0;
        end else if (flush) begin
            state       <= S_IDLE;
            counter     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        is_w_q     <= bus.mulw;
                        mplr_q     <= {ext_mplr, 1'b0};
                        mcand_q    <= wide_mcand;
                        ncand_q    <= ~wide_mcand;
                        pos_q      <= IW'(1);
                        sum_q      <= '0;
                        carry_q    <= '0;
                        counter    <= '0;
                        in_ready_q <= 1'b0;
`ifdef MUL_EARLY_OUT_EN
                        if (ext_mplr == '0 || ext_mcand == '0) begin
                            state       <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_lo_q <= '0;
                            result_hi_q <= '0;
                        end else
`endif
                        begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    sum_q   <= csa_s;
                    carry_q <= csa_c;
                    mplr_q  <= MW'($signed(mplr_q) >>> (2*PP_PER_CYCLE));
                    mcand_q <= mcand_q << (2*PP_PER_CYCLE);
                    ncand_q <= ncand_q << (2*PP_PER_CYCLE);
                    pos_q   <= pos_q << (2*PP_PER_CYCLE);
                    if (counter == (is_w_q ? LAST_W : LAST)) begin
                        state       <= S_DONE;
                        counter     <= '0;
                        out_valid_q <= 1'b1;
                        if (is_w_q) begin
                            result_lo_q <= {{(XLEN-32){prod[31]}}, prod[31:0]};
                            result_hi_q <= {XLEN{prod[31]}};
                        end else begin
                            result_lo_q <= prod[XLEN-1:0];
                            result_hi_q <= prod[2*XLEN-1:XLEN];
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    counter     <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
